// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone classic command controller.
// Status codes double as the rsp_status_o encoding.
package wb_cmd_pkg;

    localparam logic [1:0] ST_OK              = 2'd0;
    localparam logic [1:0] ST_ERR             = 2'd1;
    localparam logic [1:0] ST_RETRY_EXHAUSTED = 2'd2;
    localparam logic [1:0] ST_TIMEOUT         = 2'd3;

    typedef enum logic [1:0] {
        WB_OK              = ST_OK,
        WB_ERR             = ST_ERR,
        WB_RETRY_EXHAUSTED = ST_RETRY_EXHAUSTED,
        WB_TIMEOUT         = ST_TIMEOUT
    } wb_status_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } wb_state_e;

    // Width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_req_timer.sv
// Request-hold timer: counts cycles a Wishbone request waits without a
// termination and flags expiry on the last allowed cycle (TIMEOUT-1).
module wb_req_timer
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = cnt_width(TIMEOUT);

    logic [TW-1:0] tmo_cnt;

    assign expired_o = (tmo_cnt == TW'(TIMEOUT - 1));

    // Saturates at the expiry value so the counter can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            tmo_cnt <= '0;
        end else if (en_i && !expired_o) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/wb_classic_cmd_controller.sv
// Turns valid/ready read/write commands into single Wishbone classic cycles,
// with internal retry/backoff and timeout, and returns one response per command.
module wb_classic_cmd_controller
    import wb_cmd_pkg::*;
#(
    parameter int DAT_WIDTH   = 8,
    parameter int MAX_RETRIES = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]           rsp_status_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    output wb_state_e            state_o
);

    localparam int RW = cnt_width(MAX_RETRIES);

    wb_state_e            state, state_n;
    logic [RW-1:0]        retry_cnt, retry_n;
    logic                 cmd_we_q, cmd_we_n;
    logic [DAT_WIDTH-1:0] cmd_dat_q, cmd_dat_n;
    logic                 cyc_q, cyc_n;
    logic                 we_q, we_n;
    logic [DAT_WIDTH-1:0] dat_q, dat_n;
    logic                 cmd_ready_q, cmd_ready_n;
    logic                 rsp_valid_q, rsp_valid_n;
    logic [DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_n;
    wb_status_e           rsp_status_q, rsp_status_n;
    logic                 tmr_clr, tmr_en, tmr_expired;

    wb_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            retry_cnt    <= '0;
            cmd_we_q     <= 1'b0;
            cmd_dat_q    <= '0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            dat_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WB_OK;
        end else begin
            state        <= state_n;
            retry_cnt    <= retry_n;
            cmd_we_q     <= cmd_we_n;
            cmd_dat_q    <= cmd_dat_n;
            cyc_q        <= cyc_n;
            we_q         <= we_n;
            dat_q        <= dat_n;
            cmd_ready_q  <= cmd_ready_n;
            rsp_valid_q  <= rsp_valid_n;
            rsp_dat_q    <= rsp_dat_n;
            rsp_status_q <= rsp_status_n;
        end
    end

    // Next-state logic also computes every output's next value, so all
    // outputs leave the block straight from flops.
    always_comb begin
        state_n      = state;
        retry_n      = retry_cnt;
        cmd_we_n     = cmd_we_q;
        cmd_dat_n    = cmd_dat_q;
        cyc_n        = 1'b0;
        we_n         = 1'b0;
        dat_n        = '0;
        cmd_ready_n  = 1'b0;
        rsp_valid_n  = 1'b0;
        rsp_dat_n    = rsp_dat_q;
        rsp_status_n = rsp_status_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    state_n     = REQ;
                    cmd_we_n    = cmd_we_i;
                    cmd_dat_n   = cmd_dat_i;
                    cyc_n       = 1'b1;
                    we_n        = cmd_we_i;
                    dat_n       = cmd_dat_i;
                    cmd_ready_n = 1'b0;
                    retry_n     = '0;
                    tmr_clr     = 1'b1;
                end
            end
            REQ: begin
                if (err_i) begin
                    state_n      = RESP;
                    rsp_valid_n  = 1'b1;
                    rsp_dat_n    = '0;
                    rsp_status_n = WB_ERR;
                end else if (rty_i) begin
                    if (retry_cnt < RW'(MAX_RETRIES)) begin
                        state_n = BACKOFF;
                        retry_n = retry_cnt + RW'(1);
                    end else begin
                        state_n      = RESP;
                        rsp_valid_n  = 1'b1;
                        rsp_dat_n    = '0;
                        rsp_status_n = WB_RETRY_EXHAUSTED;
                    end
                end else if (ack_i) begin
                    state_n      = RESP;
                    rsp_valid_n  = 1'b1;
                    rsp_dat_n    = cmd_we_q ? '0 : dat_i;
                    rsp_status_n = WB_OK;
                end else if (tmr_expired) begin
                    state_n      = RESP;
                    rsp_valid_n  = 1'b1;
                    rsp_dat_n    = '0;
                    rsp_status_n = WB_TIMEOUT;
                end else begin
                    cyc_n  = 1'b1;
                    we_n   = cmd_we_q;
                    dat_n  = cmd_dat_q;
                    tmr_en = 1'b1;
                end
            end
            BACKOFF: begin
                state_n = REQ;
                cyc_n   = 1'b1;
                we_n    = cmd_we_q;
                dat_n   = cmd_dat_q;
                tmr_clr = 1'b1;
            end
            RESP: begin
                rsp_valid_n = 1'b1;
                if (rsp_ready_i) begin
                    state_n      = IDLE;
                    rsp_valid_n  = 1'b0;
                    cmd_ready_n  = 1'b1;
                    rsp_dat_n    = '0;
                    rsp_status_n = WB_OK;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign dat_o        = dat_q;
    assign state_o      = state;

endmodule

// File: tb/tb_wb_classic_cmd_controller.sv
// Directed bench for wb_classic_cmd_controller (DAT_WIDTH=8, MAX_RETRIES=3, TIMEOUT=15).
module tb_wb_classic_cmd_controller;
    import wb_cmd_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_we_i = 1'b0;
    logic [7:0] cmd_dat_i = 8'h00;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [7:0] rsp_dat_o;
    logic [1:0] rsp_status_o;
    logic       cyc_o, stb_o, we_o;
    logic [7:0] dat_o;
    logic       ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
    logic [7:0] dat_i = 8'h00;
    wb_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    wb_classic_cmd_controller #(
        .DAT_WIDTH(8), .MAX_RETRIES(3), .TIMEOUT(15)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .dat_o(dat_o),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .dat_i(dat_i),
        .state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_cmd(input logic we, input logic [7:0] d, output logic accepted);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_dat_i   = d;
        accepted    = cmd_ready_o;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic consume_rsp();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    // Plays the device after a command handshake. The first rty_attempts
    // attempts get rty_i on their first cycle; later attempts get `kind`
    // ({err,rty,ack}) on cycle term_cycle (0 = never). Junk ack_i is driven
    // whenever cyc_o is low. lat = edge index (handshake = 0) at which
    // rsp_valid_o is first sampled high, or -1 if it never rises.
    task automatic run_device(input logic we, input logic [7:0] d,
                              input int rty_attempts, input int term_cycle,
                              input logic [2:0] kind, input logic [7:0] rdata,
                              output int cyc_cycles, output int pulses,
                              output int gap_bad, output int stable_bad, output int lat);
        int k, gap;
        logic prev;
        cyc_cycles = 0; pulses = 0; gap_bad = 0; stable_bad = 0; lat = -1;
        k = 0; gap = 0; prev = 1'b0;
        for (int e = 0; e < 100; e++) begin
            if (rsp_valid_o) begin
                lat = e + 1;
                break;
            end
            {err_i, rty_i, ack_i} = 3'b000;
            dat_i = 8'h00;
            if (cyc_o) begin
                if (!prev) begin
                    pulses++;
                    k = 0;
                    if (pulses > 1 && gap != 1) gap_bad++;
                end
                k++;
                cyc_cycles++;
                if (we_o !== we || dat_o !== d || stb_o !== 1'b1) stable_bad++;
                if (pulses - 1 < rty_attempts) begin
                    if (k == 1) rty_i = 1'b1;
                end else if (k == term_cycle) begin
                    {err_i, rty_i, ack_i} = kind;
                    dat_i = rdata;
                end
            end else begin
                if (prev) gap = 0;
                gap++;
                if (stb_o !== 1'b0) stable_bad++;
                ack_i = 1'b1;
                dat_i = 8'hEE;
            end
            prev = cyc_o;
            step();
        end
        {err_i, rty_i, ack_i} = 3'b000;
        dat_i = 8'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        checks++;
        if ({cmd_ready_o, rsp_valid_o, cyc_o, stb_o, we_o} !== 5'b0 || dat_o !== 8'h00 ||
            rsp_dat_o !== 8'h00 || rsp_status_o !== 2'd0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b cyc=%b stb=%b we=%b dat=%h rd=%h st=%0d state=%0d, required all 0 / IDLE",
                     cmd_ready_o, rsp_valid_o, cyc_o, stb_o, we_o, dat_o, rsp_dat_o, rsp_status_o, dbg_state);
        end
        rst_i = 1'b0;
        step();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_ack2();
        logic acc;
        int cc, pu, gb, sb, lat;
        issue_cmd(1'b1, 8'hA5, acc);
        checks++;
        if (cyc_o !== 1'b1 || we_o !== 1'b1 || dat_o !== 8'hA5) begin
            errors++;
            $display("FAIL wr_first_cycle: acc=%b cyc=%b we=%b dat=%h, required 1 1 a5", acc, cyc_o, we_o, dat_o);
        end
        run_device(1'b1, 8'hA5, 0, 2, 3'b001, 8'hFF, cc, pu, gb, sb, lat);
        checks++;
        if (cc !== 2 || sb !== 0 || cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_cyc_len: cyc_cycles=%0d unstable=%0d cyc_after=%b, required 2 0 0", cc, sb, cyc_o);
        end
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd0 || rsp_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL wr_rsp: valid=%b status=%0d dat=%h, required 1 0 00", rsp_valid_o, rsp_status_o, rsp_dat_o);
        end
        consume_rsp();
        checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_rsp_done: valid=%b ready=%b, required 0 1", rsp_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_read_async_ack();
        logic acc;
        int cc, pu, gb, sb, lat;
        issue_cmd(1'b0, 8'h5A, acc);
        run_device(1'b0, 8'h5A, 0, 1, 3'b001, 8'h3C, cc, pu, gb, sb, lat);
        checks++;
        if (lat !== 2 || cc !== 1 || sb !== 0) begin
            errors++;
            $display("FAIL rd_latency: rsp edge N+%0d cyc_cycles=%0d unstable=%0d, required N+2 1 0", lat, cc, sb);
        end
        checks++;
        if (rsp_dat_o !== 8'h3C || rsp_status_o !== 2'd0) begin
            errors++;
            $display("FAIL rd_rsp: dat=%h status=%0d, required 3c 0", rsp_dat_o, rsp_status_o);
        end
        consume_rsp();
    endtask

    task automatic test_retry_then_ack();
        logic acc;
        int cc, pu, gb, sb, lat;
        issue_cmd(1'b0, 8'h42, acc);
        run_device(1'b0, 8'h42, 2, 1, 3'b001, 8'h11, cc, pu, gb, sb, lat);
        checks++;
        if (pu !== 3 || gb !== 0 || sb !== 0 || cc !== 3) begin
            errors++;
            $display("FAIL retry_pulses: pulses=%0d bad_gaps=%0d unstable=%0d cyc_cycles=%0d, required 3 0 0 3", pu, gb, sb, cc);
        end
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd0 || rsp_dat_o !== 8'h11) begin
            errors++;
            $display("FAIL retry_rsp: valid=%b status=%0d dat=%h, required 1 0 11", rsp_valid_o, rsp_status_o, rsp_dat_o);
        end
        consume_rsp();
    endtask

    task automatic test_retry_exhausted();
        logic acc;
        int cc, pu, gb, sb, lat;
        issue_cmd(1'b1, 8'hC3, acc);
        run_device(1'b1, 8'hC3, 99, 0, 3'b000, 8'h00, cc, pu, gb, sb, lat);
        checks++;
        if (pu !== 4 || gb !== 0 || sb !== 0) begin
            errors++;
            $display("FAIL exhaust_pulses: pulses=%0d bad_gaps=%0d unstable=%0d, required 4 0 0", pu, gb, sb);
        end
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd2 || rsp_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL exhaust_rsp: valid=%b status=%0d dat=%h, required 1 2 00", rsp_valid_o, rsp_status_o, rsp_dat_o);
        end
        consume_rsp();
    endtask

    task automatic test_err_priority();
        logic acc;
        int cc, pu, gb, sb, lat;
        issue_cmd(1'b0, 8'h00, acc);
        run_device(1'b0, 8'h00, 0, 1, 3'b111, 8'h99, cc, pu, gb, sb, lat);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd1 || rsp_dat_o !== 8'h00 || pu !== 1) begin
            errors++;
            $display("FAIL err_priority: valid=%b status=%0d dat=%h pulses=%0d, required 1 1 00 1",
                     rsp_valid_o, rsp_status_o, rsp_dat_o, pu);
        end
        consume_rsp();
    endtask

    task automatic test_timeout();
        logic acc;
        int cc, pu, gb, sb, lat, bad;
        issue_cmd(1'b0, 8'h77, acc);
        run_device(1'b0, 8'h77, 0, 0, 3'b000, 8'h00, cc, pu, gb, sb, lat);
        checks++;
        if (cc !== 15 || pu !== 1 || sb !== 0) begin
            errors++;
            $display("FAIL tmo_cyc_len: cyc_cycles=%0d pulses=%0d unstable=%0d, required 15 1 0", cc, pu, sb);
        end
        // Offer a new command while the response is stalled; it must not be taken.
        bad = 0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_dat_i   = 8'h12;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd3 || rsp_dat_o !== 8'h00 ||
                cmd_ready_o !== 1'b0 || cyc_o !== 1'b0) bad++;
            step();
        end
        cmd_valid_i = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tmo_hold: %0d stalled cycles off, required rsp_valid=1 status=3 ready=0 cyc=0 throughout", bad);
        end
        consume_rsp();
        checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_done: valid=%b ready=%b cyc=%b, required 0 1 0", rsp_valid_o, cmd_ready_o, cyc_o);
        end
    endtask

    task automatic test_reset_mid_req();
        logic acc;
        int rv_seen;
        issue_cmd(1'b1, 8'h5C, acc);
        step();
        checks++;
        if (cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_cyc: cyc=%b, required 1", cyc_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_req: cyc=%b stb=%b rv=%b ready=%b, required 0 0 0 0", cyc_o, stb_o, rsp_valid_o, cmd_ready_o);
        end
        step();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b, required 1", cmd_ready_o);
        end
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0) rv_seen++;
            step();
        end
        checks++;
        if (rv_seen !== 0) begin
            errors++;
            $display("FAIL rst_no_rsp: %0d cycles with rsp_valid/cyc high, required 0", rv_seen);
        end
    endtask

    task automatic test_back_to_back();
        int hs[$];
        int bad_dat;
        bad_dat = 0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_dat_i   = 8'h00;
        rsp_ready_i = 1'b1;
        ack_i       = 1'b1;
        dat_i       = 8'h6B;
        for (int e = 0; e < 12; e++) begin
            if (cmd_ready_o) hs.push_back(e);
            if (rsp_valid_o && rsp_dat_o !== 8'h6B) bad_dat++;
            step();
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        ack_i       = 1'b0;
        dat_i       = 8'h00;
        checks++;
        if (hs.size() !== 4 || hs[0] !== 0 || hs[1] !== 3 || hs[2] !== 6 || hs[3] !== 9) begin
            errors++;
            $display("FAIL b2b_spacing: %0d handshakes, first four at %0d %0d %0d %0d, required 4 at 0 3 6 9",
                     hs.size(), (hs.size() > 0) ? hs[0] : -1, (hs.size() > 1) ? hs[1] : -1,
                     (hs.size() > 2) ? hs[2] : -1, (hs.size() > 3) ? hs[3] : -1);
        end
        checks++;
        if (bad_dat !== 0) begin
            errors++;
            $display("FAIL b2b_rsp_dat: %0d responses with wrong data, required 0", bad_dat);
        end
        repeat (3) step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_ack2();
        test_read_async_ack();
        test_retry_then_ack();
        test_retry_exhausted();
        test_err_priority();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
